// File: rtl/updown_counter_n_pkg.sv
// Shared encodings for the parametrised up/down LED counter.
package updown_counter_n_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/ripple_adder_n.sv
// W-bit ripple-carry adder built from a chain of single-bit full-adder cells.
module ripple_adder_n #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/updown_counter_n.sv
// Prescaled W-bit up/down counter with step, load, and wrap/saturate limit handling.
module updown_counter_n
  import updown_counter_n_pkg::*;
#(
  parameter int unsigned     W        = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << W) - 64'd1,
  parameter int unsigned     PRESCALE = 1,
  parameter int unsigned     SATURATE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sw,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] step,
  output logic [W-1:0] leds,
  output logic         tc,
  output logic         at_max,
  output logic         at_min
);

  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  MAX_W    = W'(MAX_VAL);
  localparam logic [W-1:0]  ZERO_W   = '0;
  localparam logic          SAT_MODE = (SATURATE == MODE_SAT);

  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_nxt;
  logic [W-1:0]  leds_nxt;
  logic          tc_nxt;
  logic          tick;
  logic          up;
  logic [W-1:0]  add_b;
  logic [W-1:0]  sum;
  logic          cout;

  assign up   = (sw == DIR_UP);
  assign tick = en & (pre_cnt == LAST_PRE);

  // Down-count is leds + ~step + 1; a clear carry-out means a borrow.
  assign add_b = up ? step : ~step;

  ripple_adder_n #(.W(W)) u_adder (
    .a    (leds),
    .b    (add_b),
    .cin  (~up),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    leds_nxt = leds;
    tc_nxt   = 1'b0;
    pre_nxt  = pre_cnt;
    if (load) begin
      leds_nxt = (load_val > MAX_W) ? MAX_W : load_val;
      pre_nxt  = '0;
    end else if (en) begin
      pre_nxt = tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        if (up) begin
          if (cout || (sum > MAX_W)) begin
            leds_nxt = SAT_MODE ? MAX_W : ZERO_W;
            tc_nxt   = 1'b1;
          end else begin
            leds_nxt = sum;
            tc_nxt   = (sum == MAX_W);
          end
        end else begin
          if (!cout) begin
            leds_nxt = SAT_MODE ? ZERO_W : MAX_W;
            tc_nxt   = 1'b1;
          end else begin
            leds_nxt = sum;
            tc_nxt   = (sum == ZERO_W);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds    <= '0;
      tc      <= 1'b0;
      pre_cnt <= '0;
    end else begin
      leds    <= leds_nxt;
      tc      <= tc_nxt;
      pre_cnt <= pre_nxt;
    end
  end

  assign at_max = (leds == MAX_W);
  assign at_min = (leds == ZERO_W);

endmodule

// File: tb/tb_updown_counter_n.sv
// Randomised scoreboard bench: four counter configurations share one stimulus stream.
module tb_updown_counter_n;

  localparam int ND = 4;
  localparam int MX [ND] = '{255, 9, 200, 100};
  localparam int PS [ND] = '{4, 1, 3, 4};
  localparam int SAT[ND] = '{0, 0, 1, 1};

  typedef struct {
    int   d;
    int   cnt;
    logic tc;
    logic amax;
    logic amin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, sw = 1'b1, load = 1'b0;
  logic [7:0] load_val = '0, step = '0;

  logic [7:0] leds   [ND];
  logic       tc     [ND];
  logic       at_max [ND];
  logic       at_min [ND];

  int   m_cnt [ND];
  int   m_pre [ND];
  logic m_tc  [ND];
  exp_t exp_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.W(8), .MAX_VAL(255), .PRESCALE(4), .SATURATE(0)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .sw(sw), .load(load), .load_val(load_val), .step(step),
    .leds(leds[0]), .tc(tc[0]), .at_max(at_max[0]), .at_min(at_min[0]));
  updown_counter_n #(.W(8), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .sw(sw), .load(load), .load_val(load_val), .step(step),
    .leds(leds[1]), .tc(tc[1]), .at_max(at_max[1]), .at_min(at_min[1]));
  updown_counter_n #(.W(8), .MAX_VAL(200), .PRESCALE(3), .SATURATE(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .sw(sw), .load(load), .load_val(load_val), .step(step),
    .leds(leds[2]), .tc(tc[2]), .at_max(at_max[2]), .at_min(at_min[2]));
  updown_counter_n #(.W(8), .MAX_VAL(100), .PRESCALE(4), .SATURATE(1)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .sw(sw), .load(load), .load_val(load_val), .step(step),
    .leds(leds[3]), .tc(tc[3]), .at_max(at_max[3]), .at_min(at_min[3]));

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, req, $time);
  endtask

  task automatic push_expect();
    for (int d = 0; d < ND; d++)
      exp_q.push_back('{d, m_cnt[d], m_tc[d], logic'(m_cnt[d] == MX[d]), logic'(m_cnt[d] == 0)});
  endtask

  // Reference behaviour for one clock edge, in plain integer arithmetic.
  task automatic model_edge(input logic e, input logic s, input logic l, input int lv, input int st);
    int nxt;
    for (int d = 0; d < ND; d++) begin
      m_tc[d] = 1'b0;
      if (l) begin
        m_cnt[d] = (lv > MX[d]) ? MX[d] : lv;
        m_pre[d] = 0;
      end else if (e) begin
        if (m_pre[d] == PS[d] - 1) begin
          m_pre[d] = 0;
          nxt = s ? m_cnt[d] + st : m_cnt[d] - st;
          if (nxt > MX[d]) begin
            m_cnt[d] = (SAT[d] != 0) ? MX[d] : 0;
            m_tc[d]  = 1'b1;
          end else if (nxt < 0) begin
            m_cnt[d] = (SAT[d] != 0) ? 0 : MX[d];
            m_tc[d]  = 1'b1;
          end else begin
            m_cnt[d] = nxt;
            m_tc[d]  = s ? logic'(nxt == MX[d]) : logic'(nxt == 0);
          end
        end else begin
          m_pre[d] = m_pre[d] + 1;
        end
      end
    end
    push_expect();
  endtask

  task automatic drive(input logic e, input logic s, input logic l, input int lv, input int st);
    @(negedge clk);
    rst = 1'b0; en = e; sw = s; load = l;
    load_val = 8'(lv); step = 8'(st);
    model_edge(e, s, l, lv, st);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("async_rst_leds", d, 32'(leds[d]), 32'd0);
      check("async_rst_flags", d, {29'd0, tc[d], at_max[d], at_min[d]}, 32'b001);
      m_cnt[d] = 0; m_pre[d] = 0; m_tc[d] = 1'b0;
    end
    push_expect();
    @(posedge clk);
  endtask

  // Monitor: every output cycle pops and compares one expectation per counter.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("leds", x.d, 32'(leds[x.d]), 32'(x.cnt));
        check("tc", x.d, 32'(tc[x.d]), 32'(x.tc));
        check("at_max_min", x.d, {30'd0, at_max[x.d], at_min[x.d]}, {30'd0, x.amax, x.amin});
      end
    end
  end

  initial begin
    do_reset();
    // up-count with a reset landing mid-prescale
    repeat (6) drive(1, 1, 0, 0, 1);
    do_reset();
    repeat (12) drive(1, 1, 0, 0, 1);
    // wrap through MAX_VAL
    drive(1, 1, 1, 8, 1);
    repeat (4) drive(1, 1, 0, 0, 1);
    // saturating overflow and pushing against the limit
    drive(1, 1, 1, 195, 10);
    repeat (8) drive(1, 1, 0, 0, 10);
    // down with borrow
    drive(1, 0, 1, 3, 5);
    repeat (5) drive(1, 0, 0, 0, 5);
    // load on a tick cycle wins and restarts the prescaler
    drive(1, 1, 1, 0, 1);
    repeat (3) drive(1, 1, 0, 0, 1);
    drive(1, 1, 1, 250, 1);
    repeat (5) drive(1, 1, 0, 0, 1);
    // enable low holds everything, then direction flips mid-prescale
    repeat (10) drive(0, 1, 0, 0, 1);
    repeat (2) drive(1, 1, 0, 0, 1);
    repeat (6) drive(1, 0, 0, 0, 1);
    // step of zero at the limits
    drive(1, 1, 1, 255, 0);
    repeat (4) drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else drive(logic'($urandom_range(7) != 0), logic'($urandom_range(1)),
                 logic'($urandom_range(31) == 0), int'($urandom_range(255)),
                 ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(3)));
    end

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
